// File: rtl/alu_rr_arbiter_pkg.sv
// Shared constants for the ALU arbiter: opcode and shift-control encodings plus FSM states.
// Opcodes above OP_MAX_LEGAL are treated as illegal by the arbiter.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD       = 4'b0000;
  localparam logic [3:0] OP_SUB       = 4'b0001;
  localparam logic [3:0] OP_MUL       = 4'b0010;
  localparam logic [3:0] OP_OR        = 4'b0011;
  localparam logic [3:0] OP_AND       = 4'b0100;
  localparam logic [3:0] OP_XOR       = 4'b0101;
  localparam logic [3:0] OP_MAX_LEGAL = 4'b0101;

  localparam logic [2:0] SR_NONE = 3'b000;
  localparam logic [2:0] SR_RSH  = 3'b001;
  localparam logic [2:0] SR_LSH  = 3'b010;
  localparam logic [2:0] SR_ROR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of both request channels, the ALU-facing operand bus and the response channel.
// The slave modport is the arbiter's view; master is the environment (requesters, ALU, consumer).
interface alu_rr_arbiter_if #(
  parameter int DATA_W = 32
);

  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_in1, req1_in1, req0_in2, req1_in2;
  logic [3:0]        req0_opcode, req1_opcode;
  logic [2:0]        req0_sr_cont, req1_sr_cont;
  logic [4:0]        req0_sr_bit, req1_sr_bit;

  logic [DATA_W-1:0] alu_in1, alu_in2;
  logic [3:0]        alu_opcode;
  logic [2:0]        alu_sr_cont;
  logic [4:0]        alu_sr_bit;
  logic [DATA_W-1:0] alu_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req1_valid, req0_in1, req1_in1, req0_in2, req1_in2,
           req0_opcode, req1_opcode, req0_sr_cont, req1_sr_cont,
           req0_sr_bit, req1_sr_bit, alu_out, rsp_ready,
    output req0_ready, req1_ready, alu_in1, alu_in2, alu_opcode,
           alu_sr_cont, alu_sr_bit, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport master (
    output req0_valid, req1_valid, req0_in1, req1_in1, req0_in2, req1_in2,
           req0_opcode, req1_opcode, req0_sr_cont, req1_sr_cont,
           req0_sr_bit, req1_sr_bit, alu_out, rsp_ready,
    input  req0_ready, req1_ready, alu_in1, alu_in2, alu_opcode,
           alu_sr_cont, alu_sr_bit, rsp_valid, rsp_data, rsp_id, rsp_err
  );

endinterface

// File: rtl/alu_rr_arbiter_rr_arb2.sv
// Two-way grant: a lone valid requester wins, a tie goes to the priority pointer.
// With ALU_ARB_FIXED_PRIO_EN defined, requester 0 always wins ties and no pointer exists.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic accept_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  assign grant_valid_o = valid0_i | valid1_i;

`ifdef ALU_ARB_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, accept_i};
  assign grant_id_o    = valid1_i & ~valid0_i;

`else

  logic ptr_q;

  always_comb begin
    grant_id_o = valid1_i;
    if (valid0_i && valid1_i) begin
      grant_id_o = ptr_q;
    end
  end

  // The requester just served drops to lowest priority for the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept_i) begin
      ptr_q <= ~grant_id_o;
    end
  end

`endif

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between two requesters: grant, registered operands, fixed execute window, held response.
// Optional macro ALU_ARB_FIXED_PRIO_EN switches tie-breaking from round-robin to req0-first.
module alu_rr_arbiter #(
  parameter int DATA_W      = 32,
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_rr_arbiter_if.slave      bus
);

  import alu_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              id_q;
  logic              illegal_q;
  logic [DATA_W-1:0] alu_in1_q, alu_in2_q;
  logic [3:0]        alu_opcode_q;
  logic [2:0]        alu_sr_cont_q;
  logic [4:0]        alu_sr_bit_q;
  logic              rsp_valid_q, rsp_id_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              grant_valid, grant_id, accept;
  logic [DATA_W-1:0] in1_d, in2_d;
  logic [3:0]        raw_opcode, opcode_d;
  logic [2:0]        sr_cont_d;
  logic [4:0]        sr_bit_d;
  logic              illegal_d;

  rr_arb2 u_arb (
    .clk           (clk),
    .rst           (rst),
    .valid0_i      (bus.req0_valid),
    .valid1_i      (bus.req1_valid),
    .accept_i      (accept),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // Ready is gated by rst so no requester sees a handshake while reset is held.
  assign accept         = (state_q == ST_IDLE) && grant_valid && !rst;
  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept && grant_id;

  assign in1_d      = grant_id ? bus.req1_in1     : bus.req0_in1;
  assign in2_d      = grant_id ? bus.req1_in2     : bus.req0_in2;
  assign raw_opcode = grant_id ? bus.req1_opcode  : bus.req0_opcode;
  assign sr_cont_d  = grant_id ? bus.req1_sr_cont : bus.req0_sr_cont;
  assign sr_bit_d   = grant_id ? bus.req1_sr_bit  : bus.req0_sr_bit;
  assign illegal_d  = is_illegal_op(raw_opcode);
  // Illegal opcodes are replaced so the ALU only ever decodes defined operations.
  assign opcode_d   = illegal_d ? OP_ADD : raw_opcode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      id_q          <= 1'b0;
      illegal_q     <= 1'b0;
      alu_in1_q     <= '0;
      alu_in2_q     <= '0;
      alu_opcode_q  <= '0;
      alu_sr_cont_q <= '0;
      alu_sr_bit_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_id_q      <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            alu_in1_q     <= in1_d;
            alu_in2_q     <= in2_d;
            alu_opcode_q  <= opcode_d;
            alu_sr_cont_q <= sr_cont_d;
            alu_sr_bit_q  <= sr_bit_d;
            id_q          <= grant_id;
            illegal_q     <= illegal_d;
            cnt_q         <= CNT_INIT;
            state_q       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= illegal_q ? '0 : bus.alu_out;
            rsp_err_q   <= illegal_q;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_in1     = alu_in1_q;
  assign bus.alu_in2     = alu_in2_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_sr_cont = alu_sr_cont_q;
  assign bus.alu_sr_bit  = alu_sr_bit_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: behavioural ALU plus a timestamp-based transaction model, directed then random steps.
// Honours ALU_ARB_FIXED_PRIO_EN when deciding which requester should win a tie.
module tb_alu_rr_arbiter;

  import alu_ctrl_pkg::*;

  localparam int DATA_W = 32;
  localparam int EC     = 2;

  logic clk = 1'b0;
  logic rst;

  alu_rr_arbiter_if #(.DATA_W(DATA_W)) tbIf ();

  alu_rr_arbiter #(.DATA_W(DATA_W), .EXEC_CYCLES(EC), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tbIf)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Transaction model: busy from accept until the response is consumed; response due EC edges after accept.
  bit          mBusy, mRspValid, mPtr, mPendId, mPendErr, mRspId, mRspErr;
  int          mDue, edgeNo, lastGrant;
  bit          acceptedThisEdge;
  logic [31:0] mPendData, mRspData, mAluIn1, mAluIn2;
  logic [3:0]  mAluOp;
  logic [2:0]  mAluSc;
  logic [4:0]  mAluSb;

  function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [2:0] sc,
                                         input logic [4:0] sb);
    logic [31:0] s;
    logic [63:0] rot;
    rot = {b, b} >> sb;
    case (sc)
      SR_RSH:  s = b >> sb;
      SR_LSH:  s = b << sb;
      SR_ROR:  s = rot[31:0];
      default: s = b;
    endcase
    case (op)
      OP_ADD:  return a + s;
      OP_SUB:  return a - s;
      OP_MUL:  return a * s;
      OP_OR:   return a | s;
      OP_AND:  return a & s;
      OP_XOR:  return a ^ s;
      default: return 32'd0;
    endcase
  endfunction

  always_comb tbIf.alu_out = aluRef(tbIf.alu_opcode, tbIf.alu_in1, tbIf.alu_in2,
                                    tbIf.alu_sr_cont, tbIf.alu_sr_bit);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int who, input bit valid, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] sc, input logic [4:0] sb);
    if (who == 0) begin
      tbIf.req0_valid = valid; tbIf.req0_opcode = op; tbIf.req0_in1 = a;
      tbIf.req0_in2 = b; tbIf.req0_sr_cont = sc; tbIf.req0_sr_bit = sb;
    end else begin
      tbIf.req1_valid = valid; tbIf.req1_opcode = op; tbIf.req1_in1 = a;
      tbIf.req1_in2 = b; tbIf.req1_sr_cont = sc; tbIf.req1_sr_bit = sb;
    end
  endtask

  task automatic applyRandom(input int who, input bit valid);
    applyStimulus(who, valid, 4'($urandom_range(0, 9)), $urandom, $urandom,
                  3'($urandom_range(0, 4)), 5'($urandom));
  endtask

  task automatic modelReset();
    mBusy = 0; mRspValid = 0; mPtr = 0;
    mAluIn1 = '0; mAluIn2 = '0; mAluOp = '0; mAluSc = '0; mAluSb = '0;
  endtask

  task automatic checkAluRegs();
    checkOutput("alu_in1",     tbIf.alu_in1,     mAluIn1);
    checkOutput("alu_in2",     tbIf.alu_in2,     mAluIn2);
    checkOutput("alu_opcode",  tbIf.alu_opcode,  mAluOp);
    checkOutput("alu_sr_cont", tbIf.alu_sr_cont, mAluSc);
    checkOutput("alu_sr_bit",  tbIf.alu_sr_bit,  mAluSb);
  endtask

  task automatic checkRsp();
    checkOutput("rsp_valid", tbIf.rsp_valid, mRspValid);
    if (mRspValid) begin
      checkOutput("rsp_data", tbIf.rsp_data, mRspData);
      checkOutput("rsp_id",   tbIf.rsp_id,   mRspId);
      checkOutput("rsp_err",  tbIf.rsp_err,  mRspErr);
    end
  endtask

  // One clock: ready checked at the falling edge, registered outputs checked 1 unit after the rising edge.
  task automatic tick();
    bit v0, v1, g, acc, hs, illegal;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [2:0]  sc;
    logic [4:0]  sb;
    @(negedge clk);
    v0 = tbIf.req0_valid;
    v1 = tbIf.req1_valid;
    acc = !rst && !mBusy && (v0 || v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    g = (v0 && v1) ? 1'b0 : v1;
`else
    g = (v0 && v1) ? mPtr : v1;
`endif
    checkOutput("req0_ready", tbIf.req0_ready, acc && !g);
    checkOutput("req1_ready", tbIf.req1_ready, acc && g);
    if (g) begin
      a = tbIf.req1_in1; b = tbIf.req1_in2; op = tbIf.req1_opcode;
      sc = tbIf.req1_sr_cont; sb = tbIf.req1_sr_bit;
    end else begin
      a = tbIf.req0_in1; b = tbIf.req0_in2; op = tbIf.req0_opcode;
      sc = tbIf.req0_sr_cont; sb = tbIf.req0_sr_bit;
    end
    hs = mRspValid && tbIf.rsp_ready;
    @(posedge clk);
    #1;
    edgeNo++;
    acceptedThisEdge = acc;
    if (acc) begin
      illegal   = (op > 4'd5);
      mAluIn1   = a; mAluIn2 = b; mAluSc = sc; mAluSb = sb;
      mAluOp    = illegal ? 4'd0 : op;
      mPendData = illegal ? 32'd0 : aluRef(op, a, b, sc, sb);
      mPendErr  = illegal;
      mPendId   = g;
      mBusy     = 1;
      mDue      = edgeNo + EC;
      mPtr      = !g;
      lastGrant = g;
    end
    if (hs) begin
      mRspValid = 0;
      mBusy     = 0;
    end
    if (mBusy && !mRspValid && edgeNo == mDue) begin
      mRspValid = 1; mRspData = mPendData; mRspId = mPendId; mRspErr = mPendErr;
    end
    checkAluRegs();
    checkRsp();
  endtask

  initial begin
    int prevEdge, nGrants;
    rst = 1'b1;
    edgeNo = 0;
    tbIf.rsp_ready = 1'b0;
    applyStimulus(0, 0, '0, '0, '0, '0, '0);
    applyStimulus(1, 0, '0, '0, '0, '0, '0);
    modelReset();

    #12;
    applyStimulus(0, 1, OP_ADD, 32'd1, 32'd2, SR_NONE, 5'd0);
    #1;
    checkOutput("rst_req0_ready", tbIf.req0_ready, 1'b0);
    checkOutput("rst_rsp_data", tbIf.rsp_data, 32'd0);
    checkOutput("rst_rsp_id", tbIf.rsp_id, 1'b0);
    checkOutput("rst_rsp_err", tbIf.rsp_err, 1'b0);
    checkRsp();
    checkAluRegs();
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 0, '0, '0, '0, '0, '0);
    tbIf.rsp_ready = 1'b1;

    // ADD 5+7 from req0 alone.
    applyStimulus(0, 1, OP_ADD, 32'd5, 32'd7, SR_NONE, 5'd0);
    tick();
    checkOutput("t1_accept", acceptedThisEdge, 1'b1);
    applyStimulus(0, 0, OP_ADD, 32'd99, 32'd99, SR_NONE, 5'd0);
    for (int i = 0; i < EC; i++) tick();
    checkOutput("t1_rsp_valid", tbIf.rsp_valid, 1'b1);
    checkOutput("t1_rsp_data", tbIf.rsp_data, 32'd12);
    checkOutput("t1_rsp_id", tbIf.rsp_id, 1'b0);
    tick();

    // SUB 9-3 with the consumer stalled while both requesters wait.
    tbIf.rsp_ready = 1'b0;
    applyStimulus(0, 1, OP_SUB, 32'd9, 32'd3, SR_NONE, 5'd0);
    tick();
    applyStimulus(0, 0, OP_SUB, 32'd0, 32'd0, SR_NONE, 5'd0);
    for (int i = 0; i < EC; i++) tick();
    applyRandom(0, 1);
    applyRandom(1, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t3_hold_data", tbIf.rsp_data, 32'd6);
    end
    applyStimulus(0, 0, '0, '0, '0, '0, '0);
    applyStimulus(1, 0, '0, '0, '0, '0, '0);
    tbIf.rsp_ready = 1'b1;
    tick();
    checkOutput("t3_rsp_cleared", tbIf.rsp_valid, 1'b0);

    // Illegal opcode from req1.
    applyStimulus(1, 1, 4'b1001, 32'd40, 32'd2, SR_NONE, 5'd0);
    tick();
    checkOutput("t4_alu_opcode", tbIf.alu_opcode, 4'b0000);
    applyStimulus(1, 0, '0, '0, '0, '0, '0);
    for (int i = 0; i < EC; i++) tick();
    checkOutput("t4_rsp_data", tbIf.rsp_data, 32'd0);
    checkOutput("t4_rsp_err", tbIf.rsp_err, 1'b1);
    checkOutput("t4_rsp_id", tbIf.rsp_id, 1'b1);
    tick();

    // Shift control forwarded: 0 + (1 << 4).
    applyStimulus(0, 1, OP_ADD, 32'd0, 32'd1, SR_LSH, 5'd4);
    tick();
    applyStimulus(0, 0, '0, '0, '0, '0, '0);
    checkOutput("t5_sr_cont", tbIf.alu_sr_cont, 3'b010);
    checkOutput("t5_sr_bit", tbIf.alu_sr_bit, 5'd4);
    for (int i = 0; i < EC; i++) tick();
    checkOutput("t5_rsp_data", tbIf.rsp_data, 32'd16);
    tick();

    // Reset while req1's operation is executing.
    applyStimulus(1, 1, OP_XOR, 32'hF0F0, 32'h0FF0, SR_NONE, 5'd0);
    tick();
    applyStimulus(1, 0, '0, '0, '0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("mid_rst_rsp_data", tbIf.rsp_data, 32'd0);
    checkOutput("mid_rst_rsp_id", tbIf.rsp_id, 1'b0);
    checkAluRegs();
    checkRsp();
    applyRandom(0, 1);
    applyRandom(1, 1);
    tick();
    rst = 1'b0;

    // Both requesters valid continuously after reset.
    prevEdge = -1;
    nGrants  = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (acceptedThisEdge) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        checkOutput("rr_grant", lastGrant, 0);
`else
        checkOutput("rr_grant", lastGrant, nGrants % 2);
`endif
        if (prevEdge >= 0) checkOutput("rr_spacing", edgeNo - prevEdge, EC + 2);
        prevEdge = edgeNo;
        nGrants++;
      end
      applyRandom(0, 1);
      applyRandom(1, 1);
    end
    checkOutput("rr_grant_count", nGrants, 5);

    // Random traffic: valids may drop before ready, fields change every cycle.
    for (int i = 0; i < 400; i++) begin
      applyRandom(0, 1'($urandom_range(0, 1)));
      applyRandom(1, 1'($urandom_range(0, 1)));
      tbIf.rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
